// File: rtl/guarded_counter_pkg.sv
// Shared helpers for the guarded up/down counter.
//   res_modulus  : check modulus M = 2^G-1 for a G-bit residue
//   res_mod      : value mod M, used to build elaboration-time residue constants
//   params_legal : parameter sanity check applied by the top at elaboration
package guarded_counter_pkg;

    function automatic int unsigned res_modulus(input int unsigned g);
        return (32'd1 << g) - 32'd1;
    endfunction

    function automatic int unsigned res_mod(input longint unsigned value, input int unsigned g);
        longint unsigned m;
        m = longint'(res_modulus(g));
        return int'(value % m);
    endfunction

    // G must be at least 2 (M=1 would check nothing) and no wider than the count.
    function automatic bit params_legal(input int unsigned width, input int unsigned g);
        return (g >= 2) && (g <= width) && (g <= 31);
    endfunction

endpackage

// File: rtl/residue_fold.sv
// Combinational mod-(2^G-1) reduction of a WIDTH-bit value.
// Adds the G-bit chunks with end-around carry, then maps the all-ones
// encoding (the second representation of zero) to zero.
//   value_i : value to reduce
//   fold_o  : value_i mod (2^GUARD_BITS-1), always in 0..2^G-2
module residue_fold #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic [WIDTH-1:0]      value_i,
    output logic [GUARD_BITS-1:0] fold_o
);

    localparam int unsigned NumChunks = (WIDTH + GUARD_BITS - 1) / GUARD_BITS;
    localparam int unsigned PadWidth  = NumChunks * GUARD_BITS;

    logic [PadWidth-1:0]   padded;
    logic [GUARD_BITS-1:0] acc;
    logic [GUARD_BITS:0]   sum;

    always_comb begin
        padded = PadWidth'(value_i);
        acc    = '0;
        sum    = '0;
        for (int unsigned i = 0; i < NumChunks; i++) begin
            sum = {1'b0, acc} + {1'b0, padded[i*GUARD_BITS +: GUARD_BITS]};
            // Re-adding the carry cannot overflow again: low part is <= 2^G-2 when carry is set.
            acc = sum[GUARD_BITS-1:0] + GUARD_BITS'(sum[GUARD_BITS]);
        end
        fold_o = (&acc) ? '0 : acc;
    end

endmodule

// File: rtl/guarded_updown_counter.sv
// Up/down counter with enable, synchronous load and wrap at MAX_VALUE, guarded by
// an independently stepped mod-(2^G-1) residue register checked every cycle.
//   clk, rstn        : clock, synchronous active-low reset
//   en, up           : count enable and direction (1 = up)
//   load, load_value : synchronous load (saturated to MAX_VALUE)
//   clear_err        : clears err_sticky when no mismatch is present
//   inj_en, inj_mask : XOR fault injected into the next count only
//   out, residue     : count and shadow residue
//   tc               : terminal count (combinational)
//   err, err_sticky  : registered mismatch pulse and latched error
module guarded_updown_counter
    import guarded_counter_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      GUARD_BITS = 2,
    parameter logic [WIDTH-1:0] MAX_VALUE  = {WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  clear_err,
    input  logic                  inj_en,
    input  logic [WIDTH-1:0]      inj_mask,
    output logic [WIDTH-1:0]      out,
    output logic [GUARD_BITS-1:0] residue,
    output logic                  tc,
    output logic                  err,
    output logic                  err_sticky
);

    if (!params_legal(WIDTH, GUARD_BITS)) begin : g_bad_params
        $error("guarded_updown_counter: GUARD_BITS must satisfy 2 <= GUARD_BITS <= WIDTH");
    end

    // Residue of the wrap-down target, and the largest legal residue (M-1).
    localparam logic [GUARD_BITS-1:0] MaxRes =
        GUARD_BITS'(res_mod(64'(MAX_VALUE), GUARD_BITS));
    localparam logic [GUARD_BITS-1:0] ResTop =
        GUARD_BITS'(res_modulus(GUARD_BITS) - 32'd1);

    logic [WIDTH-1:0]      count_q, count_d, count_step, load_sat;
    logic [GUARD_BITS-1:0] res_q, res_d, load_res, count_res;
    logic                  err_q, err_d, sticky_q, sticky_d;
    logic                  at_max, at_zero, mismatch;

    assign load_sat = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    assign at_max   = (count_q == MAX_VALUE);
    assign at_zero  = (count_q == '0);

    residue_fold #(
        .WIDTH      (WIDTH),
        .GUARD_BITS (GUARD_BITS)
    ) u_fold_load (
        .value_i (load_sat),
        .fold_o  (load_res)
    );

    residue_fold #(
        .WIDTH      (WIDTH),
        .GUARD_BITS (GUARD_BITS)
    ) u_fold_check (
        .value_i (count_q),
        .fold_o  (count_res)
    );

    assign mismatch = (count_res != res_q);

    // The residue steps on its own; it only re-reads the count path on load.
    always_comb begin
        count_step = count_q;
        res_d      = res_q;
        if (load) begin
            count_step = load_sat;
            res_d      = load_res;
        end else if (en && up) begin
            if (at_max) begin
                count_step = '0;
                res_d      = '0;
            end else begin
                count_step = count_q + WIDTH'(1);
                res_d      = (res_q == ResTop) ? '0 : res_q + GUARD_BITS'(1);
            end
        end else if (en) begin
            if (at_zero) begin
                count_step = MAX_VALUE;
                res_d      = MaxRes;
            end else begin
                count_step = count_q - WIDTH'(1);
                res_d      = (res_q == '0) ? ResTop : res_q - GUARD_BITS'(1);
            end
        end
        count_d  = inj_en ? (count_step ^ inj_mask) : count_step;
        err_d    = mismatch;
        // Set wins over clear.
        sticky_d = mismatch | (sticky_q & ~clear_err);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q  <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            res_q    <= res_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign out        = count_q;
    assign residue    = res_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign tc         = en & ~load & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_guarded_updown_counter.sv
module tb_guarded_updown_counter;

    localparam int W    = 8;
    localparam int GB   = 2;
    localparam int MODV = (1 << GB) - 1;
    localparam int MAXV = 200;

    logic          clk = 1'b0;
    logic          rstn, en, up, load, clear_err, inj_en;
    logic [W-1:0]  load_value, inj_mask, out;
    logic [GB-1:0] residue;
    logic          tc, err, err_sticky;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state: the count, the guard residue, err and sticky flag.
    int m_out = 0;
    int m_res = 0;
    bit m_err = 0;
    bit m_sticky = 0;
    bit m_valid = 0;

    guarded_updown_counter #(
        .WIDTH      (W),
        .GUARD_BITS (GB),
        .MAX_VALUE  (8'(MAXV))
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .clear_err  (clear_err),
        .inj_en     (inj_en),
        .inj_mask   (inj_mask),
        .out        (out),
        .residue    (residue),
        .tc         (tc),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_cycle(input bit r, input bit e, input bit u, input bit l,
                             input int lv, input bit ce, input bit ie, input int im);
        bit mm;
        int nv;
        bit exp_tc;
        rstn = r; en = e; up = u; load = l; load_value = 8'(lv);
        clear_err = ce; inj_en = ie; inj_mask = 8'(im);
        #1;
        if (m_valid) begin
            exp_tc = e && !l && ((u && m_out == MAXV) || (!u && m_out == 0));
            check_val("tc", 32'(tc), 32'(exp_tc));
        end
        @(posedge clk);
        if (!r) begin
            m_out = 0; m_res = 0; m_err = 0; m_sticky = 0;
        end else begin
            mm       = (m_out % MODV) != m_res;
            m_sticky = mm || (m_sticky && !ce);
            m_err    = mm;
            if (l) begin
                nv    = (lv > MAXV) ? MAXV : lv;
                m_out = nv;
                m_res = nv % MODV;
            end else if (e && u) begin
                if (m_out == MAXV) begin
                    m_out = 0; m_res = 0;
                end else begin
                    m_out = (m_out + 1) % 256; m_res = (m_res + 1) % MODV;
                end
            end else if (e) begin
                if (m_out == 0) begin
                    m_out = MAXV; m_res = MAXV % MODV;
                end else begin
                    m_out = m_out - 1; m_res = (m_res + MODV - 1) % MODV;
                end
            end
            if (ie) m_out = m_out ^ (im & 255);
        end
        m_valid = 1;
        #1;
        check_val("out", 32'(out), 32'(m_out));
        check_val("residue", 32'(residue), 32'(m_res));
        check_val("err", 32'(err), 32'(m_err));
        check_val("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    initial begin
        rstn = 0; en = 0; up = 0; load = 0; load_value = '0;
        clear_err = 0; inj_en = 0; inj_mask = '0;

        // 1. Reset held with en=1
        for (int i = 0; i < 3; i++) run_cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check_val("reset_out", 32'(out), 0);

        // 2. Up-count through the wrap
        for (int i = 0; i < 205; i++) run_cycle(1, 1, 1, 0, 0, 0, 0, 0);
        check_val("up_wrap_out", 32'(out), 4);

        // 3. Down-count from 0
        run_cycle(1, 0, 0, 1, 0, 0, 0, 0);
        run_cycle(1, 1, 0, 0, 0, 0, 0, 0);
        check_val("down_wrap_out", 32'(out), 200);
        check_val("down_wrap_res", 32'(residue), 2);
        run_cycle(1, 1, 0, 0, 0, 0, 0, 0);
        check_val("down_199", 32'(out), 199);

        // 4. Loads, saturation, load beats count
        run_cycle(1, 0, 0, 1, 150, 0, 0, 0);
        check_val("load_150_res", 32'(residue), 0);
        run_cycle(1, 0, 0, 1, 255, 0, 0, 0);
        check_val("load_sat_out", 32'(out), 200);
        run_cycle(1, 0, 0, 1, 10, 0, 0, 0);
        run_cycle(1, 1, 1, 1, 5, 0, 0, 0);
        check_val("load_wins", 32'(out), 5);

        // 5. Injection, sticky behaviour, resync by load
        run_cycle(1, 0, 0, 1, 10, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 1, 1);
        check_val("inj_out", 32'(out), 11);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("inj_err", 32'(err), 1);
        run_cycle(1, 0, 0, 0, 0, 1, 0, 0);
        check_val("clear_blocked", 32'(err_sticky), 1);
        run_cycle(1, 0, 0, 1, 11, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("resync_err", 32'(err), 0);
        run_cycle(1, 0, 0, 0, 0, 1, 0, 0);
        check_val("clear_ok", 32'(err_sticky), 0);

        // 6. Blind spot, then reset in the middle of an error
        run_cycle(1, 0, 0, 1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 1, 3);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("blind_err", 32'(err), 0);
        run_cycle(1, 1, 1, 0, 0, 0, 1, 1);
        run_cycle(1, 1, 1, 0, 0, 0, 0, 0);
        check_val("mid_sticky", 32'(err_sticky), 1);
        run_cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check_val("mid_reset_out", 32'(out), 0);
        check_val("mid_reset_sticky", 32'(err_sticky), 0);

        // Randomized mix against the model
        for (int i = 0; i < 1500; i++) begin
            run_cycle($urandom_range(0, 99) != 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 1) != 0,
                      $urandom_range(0, 15) == 0,
                      int'($urandom_range(0, 255)),
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 19) == 0,
                      int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/guarded_updown_counter.md
Name: guarded_updown_counter

Overview:
- Next-generation guarded counter: parametrised up/down counter with enable, synchronous load and programmable wrap point (MAX_VALUE).
- Integrity is protected by an independently maintained modulo-(2^GUARD_BITS-1) residue register that is cross-checked against the count every cycle.
- Raises a per-cycle error pulse and a sticky error flag.
- Provides a fault-injection port so benches and in-system self-test can confirm the guard works.

Parameters:
- WIDTH, 8, counter width in bits.
- GUARD_BITS, 2, residue width G; check modulus M = 2^G-1. Constraint: 2 <= G <= WIDTH.
- MAX_VALUE, 2^WIDTH-1, terminal value; count range is 0..MAX_VALUE. Constraint: MAX_VALUE <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- en  input  1  count enable.
- up  input  1  1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value to load.
- clear_err  input  1  clears err_sticky.
- inj_en  input  1  fault-injection strobe.
- inj_mask  input  WIDTH  XOR mask applied to the count when inj_en=1.
- out  output  WIDTH  current count.
- residue  output  GUARD_BITS  shadow residue register.
- tc  output  1  terminal count (combinational).
- err  output  1  registered mismatch pulse.
- err_sticky  output  1  latched error.

Behaviour:
- Reset: one clock, synchronous active-low reset. rstn=0 at a clock edge gives out=0, residue=0, err=0, err_sticky=0. Reset overrides every other input.
- Next count, in priority order:
  - load=1: out <= min(load_value, MAX_VALUE).
  - else en=1 and up=1: out <= (out==MAX_VALUE) ? 0 : out+1.
  - else en=1 and up=0: out <= (out==0) ? MAX_VALUE : out-1.
  - else: hold.
- Injection: when inj_en=1, the next count is XORed with inj_mask after the update above. The residue register is not affected by injection.
- Residue register, updated in parallel with the count, never derived from out except on load:
  - load: residue <= fold(loaded value).
  - Up, no wrap: residue <= (residue+1) mod M.
  - Up, wrap to 0: residue <= 0.
  - Down, no wrap: residue <= (residue+M-1) mod M.
  - Down, wrap to MAX_VALUE: residue <= MAX_RES, an elaboration constant equal to MAX_VALUE mod M.
  - Hold: unchanged.
  - Residue values are always in 0..M-1. The all-ones encoding is never stored; fold maps it to 0.
- fold(x): sum the G-bit chunks of x with end-around carry, then map all-ones to 0. Result is x mod M. Purely combinational.
- Check: mismatch = (fold(out) != residue), evaluated every cycle; err <= mismatch.
  - Latency: a corrupted count visible in cycle n gives err=1 in cycle n+1.
  - err stays high for as long as the mismatch persists.
  - A mismatch persists until the next load or reset, both of which resynchronise the residue.
- err_sticky:
  - Set when mismatch=1.
  - Cleared by clear_err=1 only when mismatch=0 in that cycle; set wins over clear.
  - Cleared by reset.
- tc = en & ~load & ((up & out==MAX_VALUE) | (~up & out==0)).
- Load while en=1: load wins and no count step occurs. load_value > MAX_VALUE saturates to MAX_VALUE with no error raised.
- Detection coverage: any corruption whose value change is not a multiple of M is detected. Changes that are multiples of M are undetectable by design.

Decomposition:
- Package guarded_counter_pkg holds:
  - function res_mod(value, G) used for the MAX_RES constant;
  - residue modulus helper;
  - parameter legality checks.
- One sub-module: residue_fold (WIDTH, GUARD_BITS). Combinational G-bit chunk adder with end-around carry. Instantiated twice: once for the load path and once for the checker.

Test Plan (WIDTH=8, GUARD_BITS=2 so M=3, MAX_VALUE=200):
1. Reset: hold rstn=0 for 3 edges with en=1 -> out=0, residue=0, err=0, err_sticky=0, and no change during reset.
2. Up-count: en=1, up=1 for 205 cycles -> out runs 0..200 then wraps to 0; tc=1 only while out=200; residue == out mod 3 in every cycle; err never set.
3. Down-count from 0: en=1, up=0 -> out=200, residue=2, tc=1 on the cycle out=0; then out=199, residue=1.
4. Load: load_value=150 -> out=150, residue=0. load_value=255 -> out=200, residue=2. load=1 with en=1, up=1 at out=10 and load_value=5 -> out=5.
5. Injection: at out=10 with en=0, inj_en=1, inj_mask=0x01 -> out=11, residue=1, err=1 next cycle, err_sticky=1. clear_err while mismatched -> err_sticky remains 1. load 11 -> err=0 next cycle; then clear_err -> err_sticky=0.
6. Blind spot and mid-operation reset: at out=0, inj_mask=0x03 -> out=3, residue=0, err stays 0. Then create a mismatch, set err_sticky, and assert rstn=0 mid-count -> all outputs return to 0 on the next edge.
